// File: rtl/wb_trace_checker.sv
// rtl/wb_trace_checker.sv - writeback commit trace checker against a golden reference stream
module wb_trace_checker #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      debug_wb_pc,
  input  logic [3:0]       debug_wb_rf_we,
  input  logic [4:0]       debug_wb_rf_wnum,
  input  logic [31:0]      debug_wb_rf_wdata,
  input  logic             ref_valid,
  output logic             ref_ready,
  input  logic [31:0]      ref_pc,
  input  logic [4:0]       ref_wnum,
  input  logic [31:0]      ref_wdata,
  output logic             mismatch,
  output logic             overflow,
  output logic [31:0]      err_pc,
  output logic [4:0]       err_wnum,
  output logic [31:0]      err_wdata,
  output logic [31:0]      err_ref_wdata,
  output logic [CNT_W-1:0] commit_cnt,
  output logic [1:0]       state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT_MIS = 2'd1,
    ST_HALT_OVF = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_mem_pc    [FIFO_DEPTH];
  logic [3:0]       r_mem_we    [FIFO_DEPTH];
  logic [4:0]       r_mem_wnum  [FIFO_DEPTH];
  logic [31:0]      r_mem_wdata [FIFO_DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             r_mismatch, r_overflow;
  logic [31:0]      r_err_pc, r_err_wdata, r_err_ref_wdata;
  logic [4:0]       r_err_wnum;
  logic [CNT_W-1:0] r_cnt;

  logic [AW-1:0] w_ra, w_wa;
  logic          w_run, w_empty, w_full, w_commit, w_hs, w_match;
  logic          w_pass, w_fail, w_ovf, w_push;
  logic [31:0]   w_mask;

  assign w_ra    = r_rptr[AW-1:0];
  assign w_wa    = r_wptr[AW-1:0];
  assign w_run   = (r_state == ST_RUN);
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_wa == w_ra);

  assign ref_ready = w_run && !w_empty;
  assign w_commit  = (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
  assign w_hs      = ref_valid && ref_ready;

  // Only byte lanes written by the head entry take part in the data compare.
  assign w_mask  = {{8{r_mem_we[w_ra][3]}}, {8{r_mem_we[w_ra][2]}},
                    {8{r_mem_we[w_ra][1]}}, {8{r_mem_we[w_ra][0]}}};
  assign w_match = (r_mem_pc[w_ra] == ref_pc) && (r_mem_wnum[w_ra] == ref_wnum) &&
                   (((r_mem_wdata[w_ra] ^ ref_wdata) & w_mask) == 32'd0);

  assign w_pass = w_hs && w_match;
  assign w_fail = w_hs && !w_match;
  assign w_ovf  = w_run && w_commit && w_full && !w_pass;
  assign w_push = w_run && w_commit && !w_fail && !w_ovf;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[w_wa]    <= debug_wb_pc;
      r_mem_we[w_wa]    <= debug_wb_rf_we;
      r_mem_wnum[w_wa]  <= debug_wb_rf_wnum;
      r_mem_wdata[w_wa] <= debug_wb_rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_RUN;
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_mismatch      <= 1'b0;
      r_overflow      <= 1'b0;
      r_err_pc        <= '0;
      r_err_wnum      <= '0;
      r_err_wdata     <= '0;
      r_err_ref_wdata <= '0;
      r_cnt           <= '0;
    end else if (w_run) begin
      if (w_pass) begin
        r_rptr <= r_rptr + PTR_ONE;
        r_cnt  <= r_cnt + CNT_ONE;
      end
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_fail) begin
        r_err_pc        <= r_mem_pc[w_ra];
        r_err_wnum      <= r_mem_wnum[w_ra];
        r_err_wdata     <= r_mem_wdata[w_ra];
        r_err_ref_wdata <= ref_wdata;
        r_mismatch      <= 1'b1;
        r_state         <= ST_HALT_MIS;
      end
      // Mismatch takes precedence over overflow for the halt state.
      if (w_ovf) begin
        r_overflow <= 1'b1;
        if (!w_fail) r_state <= ST_HALT_OVF;
      end
    end
  end

  assign mismatch      = r_mismatch;
  assign overflow      = r_overflow;
  assign err_pc        = r_err_pc;
  assign err_wnum      = r_err_wnum;
  assign err_wdata     = r_err_wdata;
  assign err_ref_wdata = r_err_ref_wdata;
  assign commit_cnt    = r_cnt;
  assign state         = r_state;
endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Commit-trace checker consuming the CPU top's writeback debug interface (`debug_wb_pc`, `debug_wb_rf_we`, `debug_wb_rf_wnum`, `debug_wb_rf_wdata`). It buffers register-file commits in a small FIFO and compares each one, in order, against a golden reference stream delivered over a valid/ready handshake. The first mismatch or buffer overflow is latched with diagnostic data and halts checking. It sits directly downstream of the CPU top in the verification/FPGA harness, replacing ad-hoc trace comparison.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: commit buffer entries; power of two, ≥2.
- `CNT_W`, default 32: width of the commit counter.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `debug_wb_pc` in 32: PC of the writeback-stage instruction.
- `debug_wb_rf_we` in 4: byte-lane write enables.
- `debug_wb_rf_wnum` in 5: destination register.
- `debug_wb_rf_wdata` in 32: write data.
- `ref_valid` in 1: golden entry available.
- `ref_ready` out 1: checker consumes the golden entry this cycle.
- `ref_pc` in 32, `ref_wnum` in 5, `ref_wdata` in 32: golden commit fields.
- `mismatch` out 1: sticky; a compare failed.
- `overflow` out 1: sticky; a commit arrived while the FIFO was full.
- `err_pc` out 32, `err_wnum` out 5, `err_wdata` out 32: DUT fields of the failing entry.
- `err_ref_wdata` out 32: golden wdata of the failing entry.
- `commit_cnt` out CNT_W: number of commits that passed comparison.
- `state` out 2: 0 = RUN, 1 = HALT_MISMATCH, 2 = HALT_OVERFLOW.

## Operation
- **Commit definition.** A commit is a cycle with `debug_wb_rf_we != 0` and `debug_wb_rf_wnum != 0`. Writes to r0 and cycles with `we = 0` are ignored.
- **Push.** In RUN, each commit pushes {pc, we, wnum, wdata} into the FIFO.
- **Pop.** `ref_ready = (state == RUN) && !empty`. A handshake (`ref_valid && ref_ready`) compares the FIFO head against `ref_*`:
  - PCs must be equal.
  - wnums must be equal.
  - wdata must be equal on every byte lane whose head `we` bit is 1; other lanes are don't-care.
- **Pass.** Pop the head and increment `commit_cnt`; it wraps modulo 2^CNT_W.
- **Fail.** Do not pop. Latch `err_pc`/`err_wnum`/`err_wdata` from the head and `err_ref_wdata` from `ref_wdata`. Set `mismatch` and go to HALT_MISMATCH.
- **Overflow.** A commit while full with no pop in the same cycle sets `overflow`, goes to HALT_OVERFLOW, and drops the commit. Full with a simultaneous passing pop accepts the push; occupancy is unchanged.
- **Empty FIFO.** Empty with a commit arriving: the entry is pushed and `ref_ready` stays 0 this cycle (no bypass).
- **HALT states.** Both are terminal until `reset`. No pushes, `ref_ready = 0`, and all outputs are frozen.
- **Simultaneous events.** Overflow and mismatch in the same cycle: mismatch wins (state = HALT_MISMATCH), and `overflow` is also set.
- **Reset.**
  - The FIFO is emptied and pointers are zeroed.
  - state = RUN; `mismatch`, `overflow` = 0; all `err_*` = 0; `commit_cnt` = 0. `ref_ready` is therefore 0.
  - Reset mid-stream discards buffered entries, and a commit presented in the reset cycle is not captured.

## Timing
- All state updates on the rising edge of `clk`. `ref_ready` is combinational from registered state only, never from `ref_valid`.
- A commit presented in cycle N is at the FIFO head (if empty) after edge N. `ref_ready` is high in cycle N+1, and a handshake in N+1 updates `commit_cnt`/`mismatch` after edge N+1.
- Throughput: one push and one pop per cycle, sustained.
- Occupancy is tracked with pointers one bit wider than log2(FIFO_DEPTH): full when the MSBs differ and the rest are equal; empty when the pointers are equal. Pointers wrap naturally.

## Test plan
1. **Matched stream.** Reset, then 20 commits (pc 0x1c000000+4k, wnum 1..20, wdata k). Golden stream identical with `ref_valid` always 1. Expect `commit_cnt` = 20, `mismatch` = 0, `state` = 0.
2. **Data mismatch.** Third commit: DUT wdata 0x12345678, golden 0x12345679, we = 4'hf. Expect `mismatch` = 1, state = 1, `err_pc` = the third PC, `err_wdata` = 0x12345678, `err_ref_wdata` = 0x12345679, `commit_cnt` = 2, `ref_ready` = 0 thereafter.
3. **Byte-lane masking and ignored commits.** DUT we = 4'b0001, wdata 0xAABBCC11; golden 0x00000011. Expect a pass. A commit with wnum = 0 and wdata 0xDEAD is not pushed and does not consume a golden entry.
4. **Overflow.** `ref_valid` = 0; push `FIFO_DEPTH` commits, then one more. Expect `overflow` = 1 and state = 2 after that edge. The same sequence with a passing pop in the ninth cycle gives no overflow.
5. **Backpressure.** Toggle `ref_valid` at random over 100 matched commits at a ≤50% commit rate. Expect `commit_cnt` = 100, no overflow with depth 8.
6. **Mid-stream reset.** Assert `reset` with 3 entries buffered. Expect all outputs at reset values, then a fresh matched stream passes.
